reg_alu_pipe: RTL
=================

REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

Interface
REQ-001 Parameter DASize, 32, data width in bits; SHALL be a power of two, >= 8.
REQ-002 Parameter ADSize, 5, register address width; register count REGSize = 2**ADSize.
REQ-003 Parameter OPSize, 3, opcode width; fixed at 3.
REQ-004 clk  input  1  single clock; all state rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  instruction offered.
REQ-007 in_ready  output  1  instruction accepted when in_valid && in_ready at a rising edge.
REQ-008 OP  input  OPSize  ALU opcode.
REQ-009 S  input  1  writeback select: 0 = load DIN, 1 = ALU result.
REQ-010 DIN  input  DASize  external load data.
REQ-011 Write_ADDR, Read_ADDR_1, Read_ADDR_2  input  ADSize each  destination, source-1, source-2 registers.
REQ-012 out_valid  output  1  result held in execute stage.
REQ-013 out_ready  input  1  consumer accepts result; retire = out_valid && out_ready.
REQ-014 alu_result  output  DASize  writeback value of execute-stage instruction.
REQ-015 Overflow  output  1  signed overflow of execute-stage instruction.
REQ-016 out_waddr  output  ADSize  destination register of execute-stage instruction.
REQ-017 ovf_sticky  output  1  set by any retired instruction with Overflow = 1.
REQ-018 ovf_clr  input  1  synchronous clear of ovf_sticky.

Function
REQ-019 SHALL be two stages: read (R, combinational at acceptance) and execute (X, one-entry register holding operands, OP, S, DIN, Write_ADDR).
REQ-020 in_ready SHALL equal !out_valid || out_ready (single-entry skid-free pipeline, full throughput).
REQ-021 Acceptance SHALL load X and set out_valid at that edge; latency one cycle from acceptance to out_valid.
REQ-022 Retire without acceptance SHALL clear out_valid; retire with acceptance SHALL keep out_valid = 1 with new contents.
REQ-023 While out_valid && !out_ready, alu_result, Overflow, out_waddr SHALL hold stable.
REQ-024 Retire SHALL write alu_result into register out_waddr at that edge; no other event writes the register file.
REQ-025 Operand read SHALL bypass: if an instruction retires in the acceptance cycle and its out_waddr equals Read_ADDR_n, operand n SHALL be the retiring alu_result, else register-file contents.
REQ-026 Back-to-back dependent instructions SHALL therefore see prior results with no stall.
REQ-027 S = 0: alu_result = captured DIN, Overflow = 0.
REQ-028 S = 1 opcodes: 000 ADD, 001 SUB (src1 - src2), 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1 or 0), 110 SLL, 111 SRL (logical).
REQ-029 Shift amount SHALL be src2[log2(DASize)-1:0]; upper bits ignored.
REQ-030 ADD/SUB SHALL wrap modulo 2**DASize; Overflow = two's-complement signed overflow; Overflow = 0 for all other opcodes.
REQ-031 All registers including address 0 SHALL be writable; no hardwired zero.
REQ-032 ovf_sticky: set on retire with Overflow = 1; else cleared by ovf_clr; set wins when both occur in the same cycle.
REQ-033 Write_ADDR equal to a read address of the same instruction SHALL read the old value (write occurs only at its own retire).

Reset
REQ-034 rst = 1 SHALL immediately clear out_valid, ovf_sticky, X-stage registers, and all REGSize registers to 0; alu_result, Overflow, out_waddr read 0.
REQ-035 in_ready SHALL be 1 during and after reset; an instruction in X at reset SHALL be discarded with no writeback.
REQ-036 Accepted handshakes SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-037 Load R1=5, R2=7 (S=0), then ADD R3=R1+R2 -> alu_result 12, Overflow 0, R3=12.
REQ-038 DASize=32: R1=0x7FFFFFFF, R2=1, ADD -> alu_result 0x80000000, Overflow 1, ovf_sticky 1; SUB 0x80000000-1 -> 0x7FFFFFFF, Overflow 1.
REQ-039 Dependent stream ADD R4=R1+R2 then ADD R5=R4+R4 back-to-back, out_ready=1 -> second result 24, in_ready never drops.
REQ-040 Hold out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs stable, no register write; release -> one retire per cycle.
REQ-041 SLT -1,1 -> 1; SLL 1 by src2=0x21 -> 2; SRL 0x80000000 by 31 -> 1.
REQ-042 Assert rst while out_valid=1 -> out_valid 0 immediately, destination register reads 0; ovf_clr with simultaneous overflow retire -> ovf_sticky stays 1.

Source files
------------

// File: rtl/reg_alu_pipe_if.sv
// Instruction-in / result-out handshake bundle for reg_alu_pipe.
// master drives instructions and out_ready; slave is the pipeline.
interface reg_alu_pipe_if #(
  parameter int DASize = 32,
  parameter int ADSize = 5,
  parameter int OPSize = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [OPSize-1:0] OP;
  logic              S;
  logic [DASize-1:0] DIN;
  logic [ADSize-1:0] Write_ADDR;
  logic [ADSize-1:0] Read_ADDR_1;
  logic [ADSize-1:0] Read_ADDR_2;
  logic              out_valid;
  logic              out_ready;
  logic [DASize-1:0] alu_result;
  logic              Overflow;
  logic [ADSize-1:0] out_waddr;

  modport master (
    output in_valid, OP, S, DIN,
    output Write_ADDR, Read_ADDR_1,
    output Read_ADDR_2, out_ready,
    input  in_ready, out_valid,
    input  alu_result, Overflow,
    input  out_waddr
  );

  modport slave (
    input  in_valid, OP, S, DIN,
    input  Write_ADDR, Read_ADDR_1,
    input  Read_ADDR_2, out_ready,
    output in_ready, out_valid,
    output alu_result, Overflow,
    output out_waddr
  );
endinterface

// File: rtl/reg_alu_pipe.sv
// Two-stage register-file ALU: operand read at acceptance,
// one-entry execute stage, writeback on retire with bypass.
module reg_alu_pipe #(
  parameter int DASize = 32,
  parameter int ADSize = 5,
  parameter int OPSize = 3
) (
  input  logic clk,
  input  logic rst,
  reg_alu_pipe_if.slave bus,
  input  logic ovf_clr,
  output logic ovf_sticky
);
  localparam int REGSize = 2**ADSize;
  localparam int SHW = $clog2(DASize);
  localparam int M = DASize - 1;

  logic [DASize-1:0] rf_q [REGSize];
  logic              valid_q;
  logic [DASize-1:0] a_q, b_q, din_q;
  logic [OPSize-1:0] op_q;
  logic              s_q;
  logic [ADSize-1:0] wa_q;
  logic              sticky_q;

  logic [DASize-1:0] a_d, b_d;
  logic [DASize-1:0] sum, dif, res;
  logic              ovf;
  logic              accept, retire;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign retire = valid_q && bus.out_ready;

  assign sum = a_q + b_q;
  assign dif = a_q - b_q;

  always_comb begin
    res = din_q;
    ovf = 1'b0;
    if (s_q) begin
      unique case (op_q)
        3'b000: begin
          res = sum;
          ovf = (a_q[M] == b_q[M]) &&
                (sum[M] != a_q[M]);
        end
        3'b001: begin
          res = dif;
          ovf = (a_q[M] != b_q[M]) &&
                (dif[M] != a_q[M]);
        end
        3'b010: res = a_q & b_q;
        3'b011: res = a_q | b_q;
        3'b100: res = a_q ^ b_q;
        3'b101: res = {{(DASize-1){1'b0}},
                       $signed(a_q) < $signed(b_q)};
        3'b110: res = a_q << b_q[SHW-1:0];
        3'b111: res = a_q >> b_q[SHW-1:0];
      endcase
    end
  end

  // The retiring result is forwarded so a dependent
  // instruction accepted in the same cycle needs no stall.
  always_comb begin
    a_d = rf_q[bus.Read_ADDR_1];
    b_d = rf_q[bus.Read_ADDR_2];
    if (retire && wa_q == bus.Read_ADDR_1) a_d = res;
    if (retire && wa_q == bus.Read_ADDR_2) b_d = res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      din_q   <= '0;
      op_q    <= '0;
      s_q     <= 1'b0;
      wa_q    <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        a_q     <= a_d;
        b_q     <= b_d;
        din_q   <= bus.DIN;
        op_q    <= bus.OP;
        s_q     <= bus.S;
        wa_q    <= bus.Write_ADDR;
      end else if (retire) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGSize; i++)
        rf_q[i] <= '0;
    end else if (retire) begin
      rf_q[wa_q] <= res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (retire && ovf) begin
      sticky_q <= 1'b1;
    end else if (ovf_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.alu_result = res;
  assign bus.Overflow   = ovf;
  assign bus.out_waddr  = wa_q;
  assign ovf_sticky     = sticky_q;
endmodule
